// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory-stage load/store unit bridging the pipeline to a req/ack
//            data bus, with byte-lane steering and load extension.
// Option   : MEM_MISALIGN_TRAP_EN - trap misaligned H/W accesses instead of
//            truncating the address.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead_m,
  input  logic                  MemStore_m,
  input  logic [2:0]            MemCtrl_m,
  input  logic [DATA_WIDTH-1:0] aluResult_m,
  input  logic [DATA_WIDTH-1:0] writeData_m,
  output logic                  stall_m,
  output logic [DATA_WIDTH-1:0] readData_m,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  misalign_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_req;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [2:0]            r_ctrl;
  logic [1:0]            r_off;
  logic                  r_fault;

  logic                  w_access;
  logic                  w_misalign;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shb;
  logic [DATA_WIDTH-1:0] w_shh;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_access = MemRead_m | MemStore_m;

`ifdef MEM_MISALIGN_TRAP_EN
  // ctrl[1] set means word (including the undefined codes); ctrl[0] means half
  assign w_misalign = MemCtrl_m[1] ? (aluResult_m[1:0] != 2'b00)
                                   : (MemCtrl_m[0] & aluResult_m[0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writeData_m;
    if (!MemCtrl_m[1]) begin
      if (MemCtrl_m[0]) begin
        w_be    = aluResult_m[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{writeData_m[15:0]}};
      end else begin
        w_be    = 4'b0001 << aluResult_m[1:0];
        w_wdata = {4{writeData_m[7:0]}};
      end
    end
  end

  assign w_shb = mem_rdata >> {r_off, 3'b000};
  assign w_shh = mem_rdata >> {r_off[1], 4'b0000};

  always_comb begin
    w_load = mem_rdata;
    if (!r_ctrl[1]) begin
      if (r_ctrl[0])
        w_load = r_ctrl[2] ? {16'h0000, w_shh[15:0]} : {{16{w_shh[15]}}, w_shh[15:0]};
      else
        w_load = r_ctrl[2] ? {24'h000000, w_shb[7:0]} : {{24{w_shb[7]}}, w_shb[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ctrl  <= 3'b000;
      r_off   <= 2'b00;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_fault <= 1'b0;
          if (w_access) begin
            r_addr  <= {aluResult_m[DATA_WIDTH-1:2], 2'b00};
            r_off   <= aluResult_m[1:0];
            r_ctrl  <= MemCtrl_m;
            r_we    <= MemStore_m;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            if (w_misalign) begin
              r_fault <= 1'b1;
              r_state <= DONE;
            end else begin
              r_req   <= 1'b1;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_req <= 1'b0;
            if (!r_we)
              r_rdata <= w_load;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_fault <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall must rise in the same cycle the access appears, hence combinational
  assign stall_m        = !rst && (((r_state == IDLE) && w_access) || (r_state == REQ));
  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_be         = r_be;
  assign mem_wdata      = r_wdata;
  assign readData_m     = r_rdata;
  assign misalign_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_m;
  logic        MemStore_m;
  logic [2:0]  MemCtrl_m;
  logic [31:0] aluResult_m;
  logic [31:0] writeData_m;
  logic        stall_m;
  logic [31:0] readData_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        misalign_fault;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .MemRead_m      (MemRead_m),
    .MemStore_m     (MemStore_m),
    .MemCtrl_m      (MemCtrl_m),
    .aluResult_m    (aluResult_m),
    .writeData_m    (writeData_m),
    .stall_m        (stall_m),
    .readData_m     (readData_m),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    MemRead_m   = 1'b0;
    MemStore_m  = 1'b0;
    MemCtrl_m   = 3'b000;
    aluResult_m = 32'h0;
    writeData_m = 32'h0;
  endtask

  // One full transaction; ack is presented in the dly-th REQ cycle
  task automatic access(input logic rd, input logic st, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int dly,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    sb.push_back(exp_rd);
    @(negedge clk);
    MemRead_m   = rd;
    MemStore_m  = st;
    MemCtrl_m   = ctrl;
    aluResult_m = addr;
    writeData_m = wd;
    #1;
    chk("stall_idle", {31'b0, stall_m}, 32'd1);
    chk("req_idle",   {31'b0, mem_req}, 32'd0);
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      chk("req",   {31'b0, mem_req}, 32'd1);
      chk("stall", {31'b0, stall_m}, 32'd1);
      chk("addr",  mem_addr, exp_addr);
      chk("be",    {28'b0, mem_be}, {28'b0, exp_be});
      chk("we",    {31'b0, mem_we}, {31'b0, st});
      chk("wdata", mem_wdata, exp_wd);
      if (k == dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
    end
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk("stall_done", {31'b0, stall_m}, 32'd0);
    chk("req_done",   {31'b0, mem_req}, 32'd0);
    chk("fault_done", {31'b0, misalign_fault}, 32'd0);
    chk("rdata",      readData_m, sb.pop_front());
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ack = ~mem_ack;
    end
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_m}, 32'd0);
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_be",    {28'b0, mem_be}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", readData_m, 32'h0);
    chk("rst_fault", {31'b0, misalign_fault}, 32'd0);
    mem_ack = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk("idle_req", {31'b0, mem_req}, 32'd0);

    //     rd    st    ctrl    addr          wd             rdata          dly addr          be       wdata          readData
    access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_BEEF);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0080);
    access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
    access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 32'h0000_0100, 4'b1100, 32'h0,         32'hFFFF_8001);
    access(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_F00D, 3, 32'h0000_0100, 4'b0011, 32'h0,         32'h0000_F00D);
    access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,        2, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 32'h0000_F00D);
    access(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        5, 32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 32'h0000_F00D);
    access(1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0,        32'h1122_3344, 1, 32'h0000_0104, 4'b1111, 32'h0,         32'h1122_3344);
    access(1'b1, 1'b1, 3'b010, 32'h0000_0204, 32'h1357_9BDF, 32'h5555_5555, 1, 32'h0000_0204, 4'b1111, 32'h1357_9BDF, 32'h1122_3344);

    // Reset while waiting for ack, then a stray ack in IDLE
    @(negedge clk);
    MemRead_m   = 1'b1;
    MemCtrl_m   = 3'b010;
    aluResult_m = 32'h0000_0300;
    @(negedge clk);
    chk("mid_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("mid_rst_req",   {31'b0, mem_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall_m}, 32'd0);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h9999_9999;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk("stray_req",   {31'b0, mem_req}, 32'd0);
    chk("stray_stall", {31'b0, stall_m}, 32'd0);
    chk("stray_rdata", readData_m, 32'h0);
    @(negedge clk);
    chk("stray_req2",  {31'b0, mem_req}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    MemRead_m   = 1'b1;
    MemCtrl_m   = 3'b010;
    aluResult_m = 32'h0000_0101;
    #1;
    chk("mis_stall_idle", {31'b0, stall_m}, 32'd1);
    @(negedge clk);
    chk("mis_req",   {31'b0, mem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall_m}, 32'd0);
    chk("mis_fault", {31'b0, misalign_fault}, 32'd1);
    chk("mis_rdata", readData_m, 32'h0);
    clear_inputs();
    @(negedge clk);
    chk("mis_fault_clr", {31'b0, misalign_fault}, 32'd0);
    chk("mis_req_after", {31'b0, mem_req}, 32'd0);
`else
    access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h5566_7788, 1, 32'h0000_0100, 4'b1111, 32'h0, 32'h5566_7788);
    access(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'h7FFF_0000, 1, 32'h0000_0100, 4'b1100, 32'h0, 32'h0000_7FFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
